// File: rtl/vx_fpu_dispatch.sv
// FP core dispatcher: steers requests to one of NUM_FPC cores and merges their
// responses round-robin into a single registered output stage.
`timescale 1ns/1ps
module vx_fpu_dispatch #(
  parameter int unsigned NUM_FPC     = 10,
  parameter int unsigned LANES       = 4,
  parameter int unsigned TAGW        = 4,
  parameter int unsigned MAX_PENDING = 8,
  localparam int unsigned FPC_BITS   = (NUM_FPC > 1) ? $clog2(NUM_FPC) : 1,
  localparam int unsigned PCNTW      = (MAX_PENDING > 0) ? $clog2(MAX_PENDING + 1) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [TAGW-1:0]               tag_in,
  input  logic [FPC_BITS-1:0]           core_sel,
  output logic [NUM_FPC-1:0]            core_valid_in,
  input  logic [NUM_FPC-1:0]            core_ready_in,
  input  logic [NUM_FPC-1:0]            core_valid_out,
  output logic [NUM_FPC-1:0]            core_ready_out,
  input  logic [NUM_FPC*LANES*32-1:0]   core_result,
  input  logic [NUM_FPC-1:0]            core_has_fflags,
  input  logic [NUM_FPC*LANES*5-1:0]    core_fflags,
  input  logic [NUM_FPC*TAGW-1:0]       core_tag_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [LANES*32-1:0]           result,
  output logic [LANES*5-1:0]            fflags,
  output logic                          has_fflags,
  output logic [TAGW-1:0]               tag_out,
  output logic [PCNTW-1:0]              pending,
  output logic                          sel_err
);

  typedef struct packed {
    logic [LANES*32-1:0] result;
    logic [LANES*5-1:0]  fflags;
    logic                has_fflags;
    logic [TAGW-1:0]     tag;
  } resp_t;

  resp_t                resp_q, resp_d;
  logic                 valid_q, valid_d;
  logic [FPC_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PCNTW-1:0]     pending_q, pending_d;
  logic                 sel_err_q, sel_err_d;

  logic                 room, sel_ok, sel_ready;
  logic                 in_fire, out_fire, accept;
  logic                 any_valid;
  logic [FPC_BITS-1:0]  grant;
  int unsigned          arb_idx;

  // The tag travels to the cores on an external path; it is not needed here.
  logic unused_tag_in;
  assign unused_tag_in = ^tag_in;

  assign room     = (pending_q < PCNTW'(MAX_PENDING));
  assign sel_ok   = (32'(core_sel) < NUM_FPC);
  assign in_fire  = valid_in && ready_in && sel_ok;
  assign out_fire = valid_q && ready_out;
  assign accept   = !valid_q || ready_out;

  // Request steering; an out-of-range select is swallowed with ready_in high.
  always_comb begin
    sel_ready     = 1'b0;
    core_valid_in = '0;
    for (int i = 0; i < int'(NUM_FPC); i++) begin
      if (core_sel == FPC_BITS'(i)) begin
        sel_ready        = core_ready_in[i];
        core_valid_in[i] = valid_in && room;
      end
    end
    ready_in = sel_ok ? (room && sel_ready) : 1'b1;
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_FPC.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    arb_idx   = 0;
    for (int k = 0; k < int'(NUM_FPC); k++) begin
      arb_idx = 32'(rr_ptr_q) + 32'(k);
      if (arb_idx >= NUM_FPC) arb_idx = arb_idx - NUM_FPC;
      if (!any_valid && core_valid_out[FPC_BITS'(arb_idx)]) begin
        any_valid = 1'b1;
        grant     = FPC_BITS'(arb_idx);
      end
    end
  end

  always_comb begin
    resp_d         = resp_q;
    valid_d        = valid_q;
    rr_ptr_d       = rr_ptr_q;
    core_ready_out = '0;
    if (any_valid) core_ready_out[grant] = accept;
    if (accept) begin
      valid_d = any_valid;
      if (any_valid) begin
        resp_d.result     = core_result[int'(grant)*LANES*32 +: LANES*32];
        resp_d.fflags     = core_fflags[int'(grant)*LANES*5 +: LANES*5];
        resp_d.has_fflags = core_has_fflags[grant];
        resp_d.tag        = core_tag_out[int'(grant)*TAGW +: TAGW];
        rr_ptr_d          = (32'(grant) == NUM_FPC - 1) ? '0 : grant + FPC_BITS'(1);
      end
    end
  end

  // In-flight count: simultaneous issue and retire cancel out.
  always_comb begin
    pending_d = pending_q;
    if (in_fire && !out_fire && room) begin
      pending_d = pending_q + PCNTW'(1);
    end else if (out_fire && !in_fire && (pending_q != '0)) begin
      pending_d = pending_q - PCNTW'(1);
    end
    sel_err_d = sel_err_q | (valid_in & ~sel_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q    <= '0;
      valid_q   <= 1'b0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      resp_q    <= resp_d;
      valid_q   <= valid_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign valid_out  = valid_q;
  assign result     = resp_q.result;
  assign fflags     = resp_q.fflags;
  assign has_fflags = resp_q.has_fflags;
  assign tag_out    = resp_q.tag;
  assign pending    = pending_q;
  assign sel_err    = sel_err_q;

endmodule

// File: doc/vx_fpu_dispatch.md
VX_FPU_DISPATCH -- requirements
Module: VX_fpu_dispatch

Interface
REQ-001 SHALL have parameter NUM_FPC, default 10, number of attached FP cores (2..16); FPC_BITS = LOG2UP(NUM_FPC).
REQ-002 SHALL have parameter LANES, default 4, lanes per operation.
REQ-003 SHALL have parameter TAGW, default 4, tag width.
REQ-004 SHALL have parameter MAX_PENDING, default 8, maximum in-flight operations (1..255); PCNTW = LOG2UP(MAX_PENDING+1).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 valid_in / ready_in  input / output  1 / 1  request handshake.
REQ-008 tag_in  input  TAGW  request tag (forwarded to cores externally).
REQ-009 core_sel  input  FPC_BITS  target core index for the current request.
REQ-010 core_valid_in / core_ready_in  output / input  NUM_FPC / NUM_FPC  per-core request handshake.
REQ-011 core_valid_out / core_ready_out  input / output  NUM_FPC / NUM_FPC  per-core response handshake.
REQ-012 core_result  input  NUM_FPC*LANES*32  per-core lane results.
REQ-013 core_has_fflags  input  NUM_FPC  per-core fflags-valid.
REQ-014 core_fflags  input  NUM_FPC*LANES*5  per-core lane flags {NV,DZ,OF,UF,NX}.
REQ-015 core_tag_out  input  NUM_FPC*TAGW  per-core response tag.
REQ-016 valid_out / ready_out  output / input  1 / 1  response handshake.
REQ-017 result / fflags / has_fflags / tag_out  output  LANES*32 / LANES*5 / 1 / TAGW  registered response.
REQ-018 pending  output  PCNTW  current in-flight count.
REQ-019 sel_err  output  1  sticky illegal-select flag.

Function
REQ-020 Dispatch SHALL be combinational: with room = (pending < MAX_PENDING), core_valid_in[i] = valid_in && room && core_sel==i.
REQ-021 For core_sel < NUM_FPC, ready_in SHALL equal room && core_ready_in[core_sel].
REQ-022 For core_sel >= NUM_FPC, ready_in SHALL be 1, no core_valid_in SHALL assert, the request SHALL be dropped without counting, and sel_err SHALL set on the following edge.
REQ-023 Input fire SHALL be valid_in && ready_in && core_sel < NUM_FPC; output fire SHALL be valid_out && ready_out.
REQ-024 pending SHALL increment on input fire only, decrement on output fire only, and hold when both or neither occur; it SHALL never exceed MAX_PENDING nor underflow.
REQ-025 Output SHALL be a single register stage; accept = !valid_out || ready_out.
REQ-026 Arbitration SHALL be round-robin: among i with core_valid_out[i], grant the first index at or after rr_ptr, wrapping modulo NUM_FPC.
REQ-027 core_ready_out SHALL be one-hot: only core_ready_out[grant] = accept, and only when some core is valid; all others SHALL be 0.
REQ-028 On grant && accept, the output register SHALL load the granted core's result, fflags, has_fflags and tag, valid_out SHALL be 1 next cycle, and rr_ptr SHALL become (grant+1) mod NUM_FPC.
REQ-029 When accept holds and no core is valid, valid_out SHALL clear next cycle; rr_ptr SHALL hold.
REQ-030 While valid_out && !ready_out, all output fields SHALL hold stable.
REQ-031 Latency from core_valid_out to valid_out SHALL be exactly 1 cycle when accept holds; sustained throughput SHALL be 1 response/cycle.
REQ-032 Same-cycle drain and load SHALL be supported, with no bubble.

Reset
REQ-033 While reset is high: valid_out=0, pending=0, rr_ptr=0, sel_err=0, result/fflags/tag_out/has_fflags=0.
REQ-034 Reset asserted mid-operation SHALL discard the output register and the pending count immediately, without waiting for clk.
REQ-035 Combinational outputs (ready_in, core_valid_in, core_ready_out) SHALL follow REQ-020..027 from reset state values.

Verification
REQ-036 Reset release, core_sel=3, core_ready_in[3]=1, valid_in 1 cycle -> core_valid_in=0x008, pending=1; core 3 responds tag 5 -> valid_out next cycle, tag_out=5; ready_out=1 -> pending=0.
REQ-037 MAX_PENDING=8, ready_out=0, 8 fires -> pending=8, ready_in=0, core_valid_in=0 on 9th; one output fire -> ready_in=1 again.
REQ-038 Cores 0, 4, 9 valid every cycle, ready_out=1 -> grant sequence 0,4,9,0,4,9 with one response per cycle; no core starves.
REQ-039 ready_out=0 for 5 cycles with core 2 valid -> result and tag_out stable, core_ready_out=0; release -> core 2 drained next cycle.
REQ-040 core_sel=12 with NUM_FPC=10 -> ready_in=1, no core_valid_in, pending unchanged, sel_err=1 until reset.
REQ-041 Reset asserted asynchronously with valid_out=1, pending=3 -> valid_out=0 and pending=0 before next clk edge.
